seq_detect_ctrl: RTL and testbench
==================================

Name: seq_detect_ctrl

Overview:
- Run-controller wrapped around a programmable serial pattern detector, generalising the team's fixed 101 Mealy detectors.
- Software or a host FSM loads pattern, length, overlap mode and target match count, then pulses start.
- The block arms the detector, qualifies serial bits with in_valid and counts matches.
- It reports done when the target count is reached, and supports abort and configuration-error reporting.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits.
- LEN_W, 4: width of cfg_len; must hold MAX_LEN.
- CNT_W, 8: width of the target and match counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- cfg_pattern  input  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received, bit [0] the last.
- cfg_len  input  LEN_W  pattern length; legal range 1..MAX_LEN.
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_target  input  CNT_W  matches until done; 0 = free-run until abort.
- start  input  1  one-cycle request; latches cfg_* and begins a run.
- abort  input  1  terminates the run, returns to IDLE.
- in_valid  input  1  qualifies in.
- in  input  1  serial data bit.
- y  output  1  Mealy match flag, combinational, same cycle as the final matching bit.
- match_cnt  output  CNT_W  matches in the current or last run.
- busy  output  1  high in ARM and RUN.
- done  output  1  high while in DONE.
- err  output  1  one-cycle pulse on start with an illegal cfg_len.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; history, fill count, shadow config and match_cnt = 0.
  - y=0, busy=0, done=0, err=0.
  - Applies immediately, mid-run included; no match is reported in the reset cycle.
- States: IDLE, ARM, RUN, DONE.
- IDLE:
  - start with cfg_len=0 or cfg_len>MAX_LEN: err=1 for the next cycle only; stay IDLE; match_cnt unchanged.
  - start with legal cfg_len: latch cfg_pattern, cfg_len, cfg_overlap, cfg_target into shadow registers; go to ARM.
  - cfg_* changes after that latch have no effect until the next start.
- ARM (exactly one cycle):
  - clear history shift register, fill count and match_cnt; go to RUN.
  - in is ignored in this cycle.
- RUN:
  - Each cycle with in_valid=1: history <= {history[MAX_LEN-2:0], in}; fill <= min(fill+1, MAX_LEN).
  - Cycles with in_valid=0 leave history and fill unchanged, and y=0.
  - match = in_valid & (fill+1 >= len) & (low len bits of {history,in} == low len bits of shadow pattern).
  - y = match, and only in RUN; y is 0 in all other states.
  - On match: match_cnt increments.
  - Non-overlap mode: fill is cleared to 0, so no bit of a matched window is reused.
  - Overlap mode: fill and history keep shifting normally.
  - If target != 0 and match_cnt+1 == target on a match: go to DONE. match_cnt ends equal to target.
  - start in RUN is ignored.
- DONE:
  - done=1, busy=0; match_cnt held.
  - start: validity check as in IDLE, then ARM.
  - abort: go to IDLE.
- Abort:
  - Takes effect in ARM, RUN or DONE; next state IDLE.
  - y is forced to 0 and match_cnt does not update in the abort cycle.
  - match_cnt keeps its last value.
  - abort and start in the same cycle: abort wins, start dropped.
- Arithmetic:
  - match_cnt wraps modulo 2^CNT_W in free-run mode (target=0); no saturation.
  - fill saturates at MAX_LEN.
- Latency:
  - start to first sampled bit: 2 cycles (ARM then RUN).
  - Final matching bit to done: 1 cycle.

Decomposition:
- Shared package seq_detect_pkg holds:
  - the state enum (IDLE/ARM/RUN/DONE);
  - MAX_LEN, LEN_W, CNT_W defaults;
  - a config struct (pattern, len, overlap, target).
- One sub-module, pattern_match_core:
  - owns the history shift register, fill counter and the compare that produces match;
  - inputs: clear, shift_en, in, shadow config, overlap;
  - outputs: the combinational match.
- seq_detect_ctrl holds the FSM, shadow registers and match counter.

Test Plan:
- Pattern 101, len=3, overlap=0, target=0; stream 1,0,1,0,1,0,1,1,0,1,1 with in_valid=1 every cycle -> y on bits 3, 7 and 10; match_cnt=3; busy stays 1.
- Same stream with overlap=1 -> y on bits 3, 5, 7 and 10; match_cnt=4.
- Pattern 101, target=2, overlap=1, same stream -> done=1 the cycle after bit 5; match_cnt=2; y=0 on bit 7; busy=0.
- start with cfg_len=0, then with cfg_len=9 -> err pulses for one cycle each; state stays IDLE; busy=0.
- Pattern 1101, len=4; stream 1,1,0 then in_valid=0 for 3 cycles then 1 -> exactly one y, on the final bit; no y during the invalid cycles.
- During RUN: reset=0 mid-stream -> all outputs 0 at once. Separately, abort on the cycle a match would occur -> y=0; match_cnt not incremented; IDLE next cycle.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared types and default sizes for the programmable sequence detector
package seq_detect_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_LEN_W   = 4;
  localparam int DEF_CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Run configuration at default sizes, as a host would assemble it.
  typedef struct packed {
    logic [DEF_MAX_LEN-1:0] pattern;
    logic [DEF_LEN_W-1:0]   len;
    logic                   overlap;
    logic [DEF_CNT_W-1:0]   target;
  } cfg_t;

endpackage

// File: rtl/pattern_match_core.sv
// rtl/pattern_match_core.sv - history shift register, fill counter and masked pattern compare
module pattern_match_core #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               shift_en,
  input  logic               in,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap,
  output logic               match
);

  logic [MAX_LEN-2:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;
  logic               fill_ok;

  assign window = {hist, in};

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
  end

  // A window only counts once enough valid bits have arrived since the last clear.
  assign fill_ok = (({1'b0, fill} + 1'b1) >= {1'b0, len});
  assign match   = shift_en & fill_ok & (((window ^ pattern) & mask) == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en) begin
      hist <= window[MAX_LEN-2:0];
      if (match && !overlap)
        fill <= '0;
      else if (fill != LEN_W'(MAX_LEN))
        fill <= fill + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - run controller: shadow config, FSM and match counter around the detector
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               abort,
  input  logic               in_valid,
  input  logic               in,
  output logic               y,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_t             state;
  logic [MAX_LEN-1:0] sh_pattern;
  logic [LEN_W-1:0]   sh_len;
  logic               sh_overlap;
  logic [CNT_W-1:0]   sh_target;
  logic               match;
  logic               len_legal;
  logic [CNT_W-1:0]   cnt_inc;

  assign len_legal = (cfg_len != '0) && ({1'b0, cfg_len} <= (LEN_W+1)'(MAX_LEN));
  assign cnt_inc   = match_cnt + 1'b1;
  assign y         = (state == ST_RUN) & match;

  pattern_match_core #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == ST_ARM),
    .shift_en ((state == ST_RUN) & in_valid & ~abort),
    .in       (in),
    .pattern  (sh_pattern),
    .len      (sh_len),
    .overlap  (sh_overlap),
    .match    (match)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      sh_pattern <= '0;
      sh_len     <= '0;
      sh_overlap <= 1'b0;
      sh_target  <= '0;
      match_cnt  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (state == ST_DONE && abort) begin
            state <= ST_IDLE;
            done  <= 1'b0;
          end else if (start) begin
            if (len_legal) begin
              sh_pattern <= cfg_pattern;
              sh_len     <= cfg_len;
              sh_overlap <= cfg_overlap;
              sh_target  <= cfg_target;
              state      <= ST_ARM;
              busy       <= 1'b1;
              done       <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_ARM: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            match_cnt <= '0;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (match) begin
            match_cnt <= cnt_inc;
            // A zero target means free-run; the counter simply wraps.
            if (sh_target != '0 && cnt_inc == sh_target) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb/tb_seq_detect_ctrl.sv - directed table-driven bench for seq_detect_ctrl
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic [7:0] cfg_target;
  logic       start, abort, in_valid, in_bit;
  logic       y, busy, done, err;
  logic [7:0] match_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic v;
    logic b;
    logic exp_y;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic [7:0] tgt;
    int         n;
    logic [15:0] bits;
    logic [15:0] ys;
    logic [7:0] exp_cnt;
    logic       exp_busy;
    logic       exp_done;
  } run_t;

  vec_t vq[$];

  seq_detect_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .start       (start),
    .abort       (abort),
    .in_valid    (in_valid),
    .in          (in_bit),
    .y           (y),
    .match_cnt   (match_cnt),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic load_stream(input int n, input logic [15:0] bits, input logic [15:0] ys);
    vq.delete();
    for (int i = 0; i < n; i++) vq.push_back('{1'b1, bits[n-1-i], ys[n-1-i]});
  endtask

  task automatic run_vecs(input string nm);
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      in_valid = vq[i].v;
      in_bit   = vq[i].b;
      #1 chk($sformatf("%s_y[%0d]", nm, i + 1), y, vq[i].exp_y);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                          input logic [7:0] tgt);
    @(negedge clk);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_target  = tgt;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble the live config to show the shadow copy is what matters.
    cfg_pattern = 8'hFF;
    cfg_len     = 4'd2;
    chk("arm_busy", busy, 1);
  endtask

  task automatic do_abort();
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  run_t runs[2];

  initial begin
    runs[0] = '{"nonovl", 8'b101, 4'd3, 1'b0, 8'd0, 11, 16'b10101011011, 16'b00100010010, 8'd3, 1'b1, 1'b0};
    runs[1] = '{"ovl",    8'b101, 4'd3, 1'b1, 8'd0, 11, 16'b10101011011, 16'b00101010010, 8'd4, 1'b1, 1'b0};

    reset = 1'b0; start = 0; abort = 0; in_valid = 0; in_bit = 0;
    cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0; cfg_target = 0;
    repeat (2) @(negedge clk);
    chk("rst_y", y, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", match_cnt, 0);
    reset = 1'b1;

    for (int r = 0; r < 2; r++) begin
      do_start(runs[r].pat, runs[r].len, runs[r].ovl, runs[r].tgt);
      load_stream(runs[r].n, runs[r].bits, runs[r].ys);
      run_vecs(runs[r].name);
      settle();
      chk({runs[r].name, "_cnt"}, match_cnt, runs[r].exp_cnt);
      chk({runs[r].name, "_busy"}, busy, runs[r].exp_busy);
      chk({runs[r].name, "_done"}, done, runs[r].exp_done);
      do_abort();
    end

    // Target of two: finishes on bit 5, later bits are not seen.
    do_start(8'b101, 4'd3, 1'b1, 8'd2);
    load_stream(5, 16'b10101, 16'b00101);
    run_vecs("tgt_a");
    settle();
    chk("tgt_done", done, 1);
    chk("tgt_busy", busy, 0);
    chk("tgt_cnt", match_cnt, 2);
    load_stream(6, 16'b011011, 16'b000000);
    run_vecs("tgt_b");
    settle();
    chk("tgt_cnt_hold", match_cnt, 2);
    chk("tgt_done_hold", done, 1);
    do_abort();
    chk("tgt_abort_done", done, 0);

    // Illegal lengths from IDLE.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      cfg_len = (k == 0) ? 4'd0 : 4'd9;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("err_pulse_%0d", k), err, 1);
      chk($sformatf("err_busy_%0d", k), busy, 0);
      @(negedge clk);
      chk($sformatf("err_clear_%0d", k), err, 0);
      chk($sformatf("err_busy2_%0d", k), busy, 0);
      chk($sformatf("err_cnt_%0d", k), match_cnt, 2);
    end

    // 1101 with an invalid gap before the final bit.
    do_start(8'b00001101, 4'd4, 1'b0, 8'd0);
    vq.delete();
    vq.push_back('{1'b1, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 3; i++) vq.push_back('{1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b1});
    run_vecs("gap");
    settle();
    chk("gap_cnt", match_cnt, 1);
    do_abort();

    // Abort on the cycle a match would occur.
    do_start(8'b101, 4'd3, 1'b1, 8'd0);
    load_stream(4, 16'b1010, 16'b0010);
    run_vecs("abt");
    @(negedge clk);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    abort    = 1'b1;
    #1 chk("abt_y", y, 0);
    @(negedge clk);
    abort = 1'b0;
    chk("abt_busy", busy, 0);
    chk("abt_cnt", match_cnt, 1);
    chk("abt_done", done, 0);
    #1 chk("abt_idle_y", y, 0);
    settle();

    // Reset in the middle of a run.
    do_start(8'b101, 4'd3, 1'b1, 8'd0);
    load_stream(4, 16'b1010, 16'b0010);
    run_vecs("rstm");
    @(negedge clk);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    reset    = 1'b0;
    #1;
    chk("rstm_y", y, 0);
    chk("rstm_busy", busy, 0);
    chk("rstm_done", done, 0);
    chk("rstm_cnt", match_cnt, 0);
    chk("rstm_err", err, 0);
    @(negedge clk);
    reset = 1'b1;
    settle();
    chk("rstm_idle_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
